// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity modes, FSM encoding,
// standard baud divisors at 100 MHz and a parity helper.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Clock cycles per bit for common baud rates with a 100 MHz clock
    localparam int BAUD_DIV_921600 = 109;
    localparam int BAUD_DIV_460800 = 217;
    localparam int BAUD_DIV_230400 = 434;
    localparam int BAUD_DIV_115200 = 868;
    localparam int BAUD_DIV_57600  = 1736;
    localparam int BAUD_DIV_38400  = 2604;
    localparam int BAUD_DIV_19200  = 5208;
    localparam int BAUD_DIV_9600   = 10417;
    localparam int BAUD_DIV_4800   = 20833;
    localparam int BAUD_DIV_2400   = 41667;
    localparam int BAUD_DIV_1200   = 83333;
    localparam int BAUD_DIV_300    = 333333;

    // Parity bit for a zero-extended character; unused data bits must be 0
    function automatic logic parity_of(input logic [MAX_DATA_BITS-1:0] data, input int mode);
        logic p;
        p = ^data;
        if (mode == PAR_ODD) begin
            return ~p;
        end else if (mode == PAR_EVEN) begin
            return p;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..BAUD_DIV-1 and flags the last cycle of each bit.
// A restart realigns the bit grid to the cycle after the restart edge.
module uart_baud_tick #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic tick
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg <= '0;
        end else if (restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format and a small input FIFO,
// sending queued characters back-to-back without idle gaps.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [DATA_BITS-1:0]            tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            tx,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

    generate
        if (BAUD_DIV < 2) begin : g_bad_baud
            $error("uart_tx_fifo: BAUD_DIV must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data
            $error("uart_tx_fifo: DATA_BITS must be in 5..9");
        end
        if (PARITY != PAR_NONE && PARITY != PAR_EVEN && PARITY != PAR_ODD) begin : g_bad_parity
            $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
            $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW  = $clog2(FIFO_DEPTH + 1);
    localparam int BCW = 4;
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    // ---------------- input FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [LW-1:0]        level_reg;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    assign fifo_empty   = (level_reg == '0);
    assign tx_ready     = (level_reg != LW'(FIFO_DEPTH));
    assign push         = tx_valid && tx_ready;
    assign fifo_level   = level_reg;
    // Read is combinational so the head can be loaded on the same edge it is popped
    assign fifo_rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    // ---------------- bit timing ----------------
    logic tick;

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rstn   (rstn),
        .restart(pop),
        .tick   (tick)
    );

    // ---------------- frame FSM ----------------
    uart_state_e          state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [BCW-1:0]       bit_cnt_reg, bit_cnt_next;
    logic                 par_reg, par_next;
    logic                 tx_reg, tx_next;
    logic                 busy_reg, busy_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            par_reg     <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            par_reg     <= par_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        par_next     = par_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_next   = ST_DATA;
                    tx_next      = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = '0;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = '0;
                        if (PARITY != PAR_NONE) begin
                            state_next = ST_PARITY;
                            tx_next    = par_reg;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (tick) begin
                    state_next   = ST_STOP;
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        if (!fifo_empty) begin
                            pop = 1'b1;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Loading a character always starts a frame, from IDLE or straight after STOP
        if (pop) begin
            state_next   = ST_START;
            tx_next      = 1'b0;
            shift_next   = fifo_rd_data;
            par_next     = parity_of(MAX_DATA_BITS'(fifo_rd_data), PARITY);
            bit_cnt_next = '0;
        end
    end

    assign busy_next = (state_next != ST_IDLE);
    assign tx        = tx_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four frame formats at BAUD_DIV=4, expected
// line waveform queued per accepted character and compared every cycle.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int NDUT  = 4;
    localparam int BAUD  = 4;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic tx;
        logic busy;
        logic first;
    } ent_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] data_a;
    logic       valid_a [NDUT];
    logic       tx_w    [NDUT];
    logic       busy_w  [NDUT];
    logic       ready_w [NDUT];
    logic [2:0] lvl_w   [NDUT];

    int dbits [NDUT] = '{8, 8, 8, 7};
    int pmode [NDUT] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_EVEN};
    int sbits [NDUT] = '{1, 1, 1, 2};

    int   checks = 0;
    int   errors = 0;
    int   cur    = 0;
    int   lvl_m  = 0;
    ent_t sb[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
        .clk(clk), .rstn(rstn), .tx_data(data_a), .tx_valid(valid_a[0]), .tx_ready(ready_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .fifo_level(lvl_w[0]));
    uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
        .clk(clk), .rstn(rstn), .tx_data(data_a), .tx_valid(valid_a[1]), .tx_ready(ready_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .fifo_level(lvl_w[1]));
    uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
        .clk(clk), .rstn(rstn), .tx_data(data_a), .tx_valid(valid_a[2]), .tx_ready(ready_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .fifo_level(lvl_w[2]));
    uart_tx_fifo #(.BAUD_DIV(BAUD), .DATA_BITS(7), .PARITY(PAR_EVEN), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7e2 (
        .clk(clk), .rstn(rstn), .tx_data(data_a[6:0]), .tx_valid(valid_a[3]), .tx_ready(ready_w[3]),
        .tx(tx_w[3]), .busy(busy_w[3]), .fifo_level(lvl_w[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: dut%0d got %0h expected %0h at %0t", tag, cur, got, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic t, input logic b, input logic f);
        ent_t e;
        e.tx    = t;
        e.busy  = b;
        e.first = f;
        return e;
    endfunction

    // Expected line waveform of one frame; an idle cycle first if the line is idle
    task automatic add_frame(input logic [7:0] d);
        logic p;
        p = 1'b0;
        if (sb.size() == 0) sb.push_back(mk(1'b1, 1'b0, 1'b0));
        for (int c = 0; c < BAUD; c++) sb.push_back(mk(1'b0, 1'b1, c == 0));
        for (int i = 0; i < dbits[cur]; i++) begin
            p = p ^ d[i];
            for (int c = 0; c < BAUD; c++) sb.push_back(mk(d[i], 1'b1, 1'b0));
        end
        if (pmode[cur] != PAR_NONE) begin
            if (pmode[cur] == PAR_ODD) p = ~p;
            for (int c = 0; c < BAUD; c++) sb.push_back(mk(p, 1'b1, 1'b0));
        end
        for (int c = 0; c < sbits[cur] * BAUD; c++) sb.push_back(mk(1'b1, 1'b1, 1'b0));
    endtask

    // One clock cycle on the selected DUT: accept, model update, compare at negedge
    task automatic step(output bit acc);
        logic [7:0] d;
        ent_t       e;
        acc = valid_a[cur] && ready_w[cur];
        d   = data_a;
        @(posedge clk);
        @(negedge clk);
        if (acc) begin
            lvl_m++;
            add_frame(d);
        end
        e = (sb.size() > 0) ? sb.pop_front() : mk(1'b1, 1'b0, 1'b0);
        if (e.first) lvl_m--;
        chk("tx", 32'(tx_w[cur]), 32'(e.tx));
        chk("busy", 32'(busy_w[cur]), 32'(e.busy));
        chk("level", 32'(lvl_w[cur]), 32'(lvl_m));
        chk("ready", 32'(ready_w[cur]), 32'(lvl_m != DEPTH));
    endtask

    task automatic run_single(input int idx, input logic [7:0] d);
        bit acc;
        int busy_cnt;
        int exp_len;
        cur      = idx;
        busy_cnt = 0;
        exp_len  = (1 + dbits[idx] + ((pmode[idx] != PAR_NONE) ? 1 : 0) + sbits[idx]) * BAUD;
        data_a       = d;
        valid_a[idx] = 1'b1;
        step(acc);
        chk("accept", 32'(acc), 32'd1);
        valid_a[idx] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step(acc);
            if (busy_w[idx]) busy_cnt++;
        end
        chk("frame_len", 32'(busy_cnt), 32'(exp_len));
        chk("drained", 32'(sb.size()), 32'd0);
        $display("frame dut%0d data %02h busy_cycles %0d", idx, d, busy_cnt);
    endtask

    initial begin
        bit acc;
        int n;
        bit saw_full;

        rstn   = 1'b0;
        data_a = '0;
        for (int i = 0; i < NDUT; i++) valid_a[i] = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            cur = i;
            chk("rst_tx", 32'(tx_w[i]), 32'd1);
            chk("rst_busy", 32'(busy_w[i]), 32'd0);
            chk("rst_level", 32'(lvl_w[i]), 32'd0);
            chk("rst_ready", 32'(ready_w[i]), 32'd1);
        end
        rstn = 1'b1;

        run_single(0, 8'h41);
        run_single(1, 8'h41);
        run_single(2, 8'h41);
        run_single(3, 8'h55);

        // Producer holds valid with 0x01..0x06; frames must follow back-to-back
        cur        = 0;
        n          = 0;
        saw_full   = 1'b0;
        data_a     = 8'h01;
        valid_a[0] = 1'b1;
        for (int k = 0; k < 400; k++) begin
            step(acc);
            if (acc) begin
                n++;
                $display("accept dut0 data %02h level %0d", 8'(n), lvl_w[0]);
                if (n == 6) valid_a[0] = 1'b0;
                else data_a = 8'(n + 1);
            end
            if (!saw_full && !ready_w[0]) begin
                saw_full = 1'b1;
                chk("accepts_at_full", 32'(n), 32'd5);
            end
            if (n == 6 && sb.size() == 0) break;
        end
        chk("burst_accepts", 32'(n), 32'd6);
        chk("burst_saw_full", 32'(saw_full), 32'd1);
        chk("burst_drained", 32'(sb.size()), 32'd0);

        // Three queued, then a push exactly on the frame-end pop edge
        n          = 0;
        data_a     = 8'hA1;
        valid_a[0] = 1'b1;
        for (int k = 0; k < 10 && n < 3; k++) begin
            step(acc);
            if (acc) begin
                n++;
                data_a = 8'(8'hA1 + n);
            end
        end
        valid_a[0] = 1'b0;
        chk("simul_prefill", 32'(lvl_w[0]), 32'd2);
        for (int k = 0; k < 60; k++) begin
            if (sb.size() > 0 && sb[0].first) break;
            step(acc);
        end
        data_a     = 8'hA4;
        valid_a[0] = 1'b1;
        step(acc);
        valid_a[0] = 1'b0;
        chk("simul_accept", 32'(acc), 32'd1);
        chk("simul_level", 32'(lvl_w[0]), 32'd2);
        $display("simultaneous push/pop dut0 level %0d", lvl_w[0]);
        for (int k = 0; k < 200 && sb.size() > 0; k++) step(acc);
        chk("simul_drained", 32'(sb.size()), 32'd0);

        // Reset in the middle of a data bit with one more character queued
        data_a     = 8'h00;
        valid_a[0] = 1'b1;
        step(acc);
        step(acc);
        valid_a[0] = 1'b0;
        repeat (10) step(acc);
        chk("pre_rst_busy", 32'(busy_w[0]), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_tx", 32'(tx_w[0]), 32'd1);
        chk("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        chk("mid_rst_level", 32'(lvl_w[0]), 32'd0);
        chk("mid_rst_ready", 32'(ready_w[0]), 32'd1);
        $display("reset mid-frame dut0 tx %0b busy %0b level %0d", tx_w[0], busy_w[0], lvl_w[0]);
        sb.delete();
        lvl_m = 0;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        repeat (10) step(acc);
        run_single(0, 8'h41);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter that generalises the fixed-character, always-start transmitter. It has a configurable frame format (data bits, parity, stop bits) and a baud divisor. A small input FIFO sits behind a valid/ready handshake, so upstream logic can queue characters and have them sent back-to-back with no idle gap. It sits between any byte producer (e.g. message sequencer) and the FTDI serial line.

Parameters:
BAUD_DIV, 868, clock cycles per bit (868 = 115200 baud at 100 MHz); must be >= 2
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, input FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
tx_data  input  DATA_BITS  character to queue
tx_valid  input  1  tx_data is valid
tx_ready  output  1  FIFO can accept (= not full)
tx  output  1  serial line, idle high, registered
busy  output  1  a frame is on the line
fifo_level  output  $clog2(FIFO_DEPTH+1)  entries currently queued

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-frame): tx=1, busy=0, fifo_level=0, tx_ready=1. The FIFO is cleared, any frame in progress is abandoned, and the FSM goes to IDLE.
- Illegal parameter values cause an elaboration-time error.
- Handshake:
  - A push happens on an edge where tx_valid && tx_ready.
  - tx_ready = !full (combinational from registered state).
  - Producer holds tx_data stable while tx_valid && !tx_ready.
  - There is no bypass: every character passes through the FIFO.
- FIFO:
  - Circular buffer with read/write pointers and fifo_level.
  - Push and pop on the same edge leave the level unchanged.
  - When full there is no push. A pop frees a slot, so tx_ready=1 from the next cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if FIFO non-empty, pop into the shift register, go to START, drive tx=0, busy=1, on that same edge.
    - Latency: accept at edge E0 into an empty FIFO while IDLE -> pop and tx falls at E1.
  - START: tx=0 for BAUD_DIV cycles -> DATA.
  - DATA: DATA_BITS bits, LSB first, BAUD_DIV cycles each -> PARITY if PARITY!=0, else STOP.
  - PARITY: even = XOR of data bits; odd = its inverse; BAUD_DIV cycles -> STOP.
  - STOP: tx=1 for STOP_BITS*BAUD_DIV cycles. At the end:
    - FIFO non-empty: pop and go to START on the same edge (no idle gap, busy stays 1).
    - Otherwise: go to IDLE, busy=0.
- Baud counter: counts 0..BAUD_DIV-1. It is restarted on every pop, so bit boundaries are aligned to the frame start.
- Frame length is exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV cycles.
- tx_data/tx_valid changes do not affect a frame already in the shift register.

Decomposition:
- Package uart_pkg holds:
  - the parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - the FSM state encoding;
  - the standard BAUD_DIV constants for common baudrates at 100 MHz, replacing the baudgen include.
- One sub-module, uart_baud_tick: BAUD_DIV counter with synchronous restart input and one-cycle tick output.
- The FIFO stays inline.

Test Plan:
- 8N1, BAUD_DIV=4, push 0x41 once: tx falls one edge after accept, then emits 0,1,0,0,0,0,0,1,0,1, each held 4 cycles (40 cycles total). busy is high exactly those 40 cycles, then tx=1.
- 8E1 and 8O1, BAUD_DIV=4, push 0x41: parity bit is 0 (even) / 1 (odd), at cycles 36..39 after the start edge; frame is 44 cycles.
- 7E2, BAUD_DIV=4, push 0x55: data 1,0,1,0,1,0,1, then parity 0, then two stop bits (8 cycles high); frame is 44 cycles.
- FIFO_DEPTH=4, tx_valid held high with 0x01..0x06: after the first pop, 4 more are accepted and tx_ready drops. Each later accept follows a frame-end pop. Frames go out back-to-back with no idle cycles, and data order is 0x01..0x06.
- Simultaneous push/pop: with level=2 at a frame end, push on the pop edge -> fifo_level stays 2.
- Reset asserted mid-DATA: tx=1 and busy=0 immediately, fifo_level=0. After release with no push, tx stays 1. A new push after release transmits a clean full frame.
